// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: byte-enabled word RAM behind a fixed-latency
// valid/ready request/response handshake, with a pipeline stall while busy.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_resp_hs;
  logic                  w_addr_err;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_accept   = (r_state == IDLE) & req_valid_i;
  assign w_access   = (r_state == WAIT) & (r_cnt == 4'd0);
  assign w_resp_hs  = (r_state == RESP) & resp_ready_i;
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];
  assign w_addr_err = (r_addr[1:0] != 2'b00) |
                      (r_addr[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid_i) w_next = WAIT;
        else             w_next = IDLE;
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_next = RESP;
        else               w_next = WAIT;
      end
      RESP: begin
        if (resp_ready_i) w_next = IDLE;
        else              w_next = RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Request latch, latency counter and registered response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_be    <= req_be_i;
        r_cnt   <= LAT_M1;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response data is cleared on handshake so it reads 0 whenever not valid
      if (w_access) begin
        r_err   <= w_addr_err;
        r_rdata <= (!r_write && !w_addr_err) ? r_mem[w_idx] : 32'd0;
      end else if (w_resp_hs) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_access && r_write && !w_addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign resp_valid_o = (r_state == RESP);
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign req_ready_o  = (r_state == IDLE) & ~rst_i;
  assign stall_o      = ~rst_i & (((r_state == IDLE) & req_valid_i) |
                                  (r_state == WAIT) |
                                  ((r_state == RESP) & ~resp_ready_i));

endmodule
